mul_div_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO result registers; completes the integer execution path alongside the combinational adder, logic, shift and set-condition functions.
- Sits in EX. The pipeline issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to it and stalls reads of HI/LO on busy.
- Operand width is parametrised; the iteration count scales with width.

---
 rtl/mul_div_unit.sv | 192 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers for the EX stage.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_op, a_neg, b_neg, last;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod, fast_fix;
`endif

    assign busy     = (state_q == StMul) || (state_q == StDiv);
    assign done     = (state_q == StFin);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        signed_op = (op == OpMult) || (op == OpDiv);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        last      = (cnt_q == CNT_W'(WIDTH - 1));

        // Shift-add step: acc_lo holds the unconsumed multiplier bits.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

        // Restoring step: acc_lo shifts out dividend bits and shifts in quotient bits.
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_lo    = {acc_lo_q[WIDTH-2:0], div_ge};

        prod      = {mul_hi, mul_lo};
        prod_fix  = neg_lo_q ? -prod : prod;
        quo_fix   = neg_lo_q ? -div_lo : div_lo;
        rem_fix   = neg_hi_q ? -div_hi : div_hi;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
        fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opb_d      = opb_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (start) begin
                    case (op)
                        OpMult, OpMultu: begin
                            cnt_d      = '0;
                            div_zero_d = 1'b0;
                            neg_lo_d   = a_neg ^ b_neg;
                            neg_hi_d   = a_neg;
`ifdef MULDIV_FAST_MUL_EN
                            {hi_d, lo_d} = fast_fix;
                            state_d      = StFin;
`else
                            opb_d      = a_mag;
                            acc_hi_d   = '0;
                            acc_lo_d   = b_mag;
                            state_d    = StMul;
`endif
                        end
                        OpDiv, OpDivu: begin
                            cnt_d      = '0;
                            div_zero_d = 1'b0;
                            neg_lo_d   = a_neg ^ b_neg;
                            neg_hi_d   = a_neg;
                            opb_d      = b_mag;
                            acc_hi_d   = '0;
                            acc_lo_d   = a_mag;
                            state_d    = StDiv;
                        end
                        OpMthi: begin
                            hi_d       = a;
                            div_zero_d = 1'b0;
                        end
                        OpMtlo: begin
                            lo_d       = a;
                            div_zero_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_hi_d = mul_hi;
                acc_lo_d = mul_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    {hi_d, lo_d} = prod_fix;
                    state_d      = StFin;
                end
            end
            StDiv: begin
                acc_hi_d = div_hi;
                acc_lo_d = div_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    // Zero divisor: quotient forced to all ones, remainder is the dividend.
                    hi_d       = rem_fix;
                    lo_d       = (opb_q == '0) ? '1 : quo_fix;
                    div_zero_d = (opb_q == '0);
                    state_d    = StFin;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            opb_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opb_q      <= opb_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus scoreboard, then handshake,
// back-to-back and reset corner sequences.
module tb_mul_div_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 0;
`else
    localparam int MulLat = 32;
`endif
    localparam int DivLat = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        logic         dz;
        int           lat;
    } exp_t;

    vec_t   tv[$];
    exp_t   sbq[$];
    int     applied = 0;
    int     miscompares = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic   m_dz = 1'b0;

    function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] x, y, h, l,
                                input logic z);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.hi = h; v.lo = l; v.dz = z;
        return v;
    endfunction

    function automatic exp_t mke(input logic [W-1:0] h, l, input logic z, input int lat);
        exp_t e;
        e.hi = h; e.lo = l; e.dz = z; e.lat = lat;
        return e;
    endfunction

    // Reference arithmetic in 64-bit so -2^31 / -1 does not overflow.
    function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, y);
        longint       sx, sy, q, r;
        logic [63:0]  p;
        vec_t         v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v = mk(o, x, y, '0, '0, 1'b0);
        case (o)
            3'b000: begin p = 64'(sx * sy); v.hi = p[63:32]; v.lo = p[31:0]; end
            3'b001: begin p = {32'b0, x} * {32'b0, y}; v.hi = p[63:32]; v.lo = p[31:0]; end
            default: begin
                if (y == '0) begin
                    v.hi = x; v.lo = '1; v.dz = 1'b1;
                end else if (o == 3'b010) begin
                    q = sx / sy; r = sx % sy;
                    v.lo = q[31:0]; v.hi = r[31:0];
                end else begin
                    v.lo = x / y; v.hi = x % y;
                end
            end
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [63:0] act, exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s: got %h, want %h", tag, fld, act, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [W-1:0] x, y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic collect(input string tag, input int n);
        exp_t e;
        if (sbq.size() == 0) begin
            chk(tag, "sb_empty", 64'(sbq.size()), 64'd1);
        end else begin
            e = sbq.pop_front();
            chk(tag, "latency", 64'(n), 64'(e.lat));
            chk(tag, "hi", hi, e.hi);
            chk(tag, "lo", lo, e.lo);
            chk(tag, "div_zero", div_zero, e.dz);
            m_hi = e.hi; m_lo = e.lo; m_dz = e.dz;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n, lat, seen;
        vec_t v;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;

        tv.push_back(mk(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0));
        tv.push_back(mk(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 0));
        tv.push_back(mk(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0));
        tv.push_back(mk(3'b011, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0));
        tv.push_back(mk(3'b011, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1));
        tv.push_back(mk(3'b101, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0BAD_F00D, 0));
        tv.push_back(mk(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0));
        tv.push_back(mk(3'b100, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h0, 0));
        tv.push_back(mk(3'b001, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 0));
        tv.push_back(mk(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0));
        tv.push_back(mk(3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1));
        tv.push_back(mk(3'b110, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 0));
        tv.push_back(mk(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0));
        tv.push_back(mk(3'b000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 0));
        for (int k = 0; k < 6; k++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (k % 2 == 1) ? 32'($urandom_range(1, 17)) : $urandom;
            tv.push_back(model(rop, ra, rb));
        end

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "busy", busy, 1'b0);
        chk("reset", "done", done, 1'b0);
        chk("reset", "div_zero", div_zero, 1'b0);
        chk("reset", "hi", hi, '0);
        chk("reset", "lo", lo, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tv[i]) begin
            v = tv[i];
            if (v.op[2] == 1'b0) begin
                lat = (v.op[1] == 1'b0) ? MulLat : DivLat;
                sbq.push_back(mke(v.hi, v.lo, v.dz, lat));
                launch(v.op, v.a, v.b);
                chk($sformatf("vec%0d", i), "busy", busy, (lat != 0));
                wait_done(n);
                collect($sformatf("vec%0d", i), n);
            end else begin
                launch(v.op, v.a, v.b);
                if (v.op == 3'b100) begin
                    m_hi = v.hi; m_dz = 1'b0;
                end else if (v.op == 3'b101) begin
                    m_lo = v.lo; m_dz = 1'b0;
                end
                chk($sformatf("vec%0d", i), "done", done, 1'b0);
                chk($sformatf("vec%0d", i), "busy", busy, 1'b0);
                chk($sformatf("vec%0d", i), "hi", hi, m_hi);
                chk($sformatf("vec%0d", i), "lo", lo, m_lo);
                chk($sformatf("vec%0d", i), "div_zero", div_zero, m_dz);
            end
        end

        // A start pulsed while busy must be dropped without disturbing the running op.
`ifdef MULDIV_FAST_MUL_EN
        sbq.push_back(mke(32'h0000_0002, 32'hFFFF_FFF2, 1'b0, DivLat));
        launch(3'b010, 32'd100, 32'hFFFF_FFF9);
        repeat (3) @(posedge clk);
        #1;
        op = 3'b001; a = 32'd3; b = 32'd5; start = 1'b1;
`else
        sbq.push_back(mke(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MulLat));
        launch(3'b000, 32'hFFFF_FFFD, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        op = 3'b010; a = 32'd100; b = 32'd0; start = 1'b1;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        collect("ignore", n + 4);
        @(posedge clk); #1;
        chk("ignore", "no_extra_done", done, 1'b0);

        // Second op accepted in the FIN cycle of the first.
        sbq.push_back(mke(32'h0000_0002, 32'hFFFF_FFF2, 1'b0, DivLat));
        launch(3'b010, 32'd100, 32'hFFFF_FFF9);
        wait_done(n);
        collect("b2b_first", n);
        sbq.push_back(mke(32'h0000_000F, 32'h0FFF_FFFF, 1'b0, DivLat));
        launch(3'b011, 32'hFFFF_FFFF, 32'd16);
        wait_done(n);
        chk("b2b", "done_gap", 64'(n + 1), 64'd33);
        collect("b2b_second", n);

        // Reset five cycles into a divide aborts it.
        launch(3'b010, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid", "busy", busy, 1'b0);
        chk("rst_mid", "done", done, 1'b0);
        chk("rst_mid", "div_zero", div_zero, 1'b0);
        chk("rst_mid", "hi", hi, '0);
        chk("rst_mid", "lo", lo, '0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk("rst_mid", "late_done", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
